// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit paths.
//   uart_rx_state_t       - receive FSM state encoding
//   UART_DATA_W           - data bits per frame
//   CLKS_PER_BIT_9600_50M - bit period at 9600 baud on the 50 MHz clock
package uart_pkg;
  localparam int UART_DATA_W           = 8;
  localparam int CLKS_PER_BIT_9600_50M = 5208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head word.
//   clk, rst        - clock, synchronous active-high reset
//   push, din       - write request and data (dropped when full unless popping)
//   pop             - read request (ignored when empty)
//   dout            - registered head entry, valid while !empty
//   full, empty     - occupancy flags
//   count           - entries held, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Head register tracks mem[rd_ptr]; the incoming word becomes head
      // directly when it lands in an empty (or just-emptied) FIFO.
      if (pop_ok) begin
        if (push_ok && count == (AW+1)'(1)) dout <= din;
        else                                 dout <= mem[rd_nxt];
      end else if (push_ok && empty) begin
        dout <= din;
      end
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a byte FIFO on the consumer side.
//   clk, rst           - clock, synchronous active-high reset
//   rxd                - asynchronous serial input, idle high, LSB first
//   rx_data/rx_valid   - FIFO head byte and not-empty flag
//   rx_ready           - consumer pops the head when rx_valid
//   rx_count           - bytes queued
//   frame_err          - one-cycle pulse on a low stop bit
//   overrun            - sticky, set when a byte is dropped on a full FIFO
//   overrun_clr        - clears overrun (a simultaneous new overrun wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_50M,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  output logic [UART_DATA_W-1:0]      rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        overrun_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic sync1, rxs;
  uart_rx_state_t state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             idx, idx_n;
  logic [UART_DATA_W-1:0] shift, shift_n;
  logic push, ferr_n, pop, full, empty, ovr_set;

  // Flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      frame_err <= ferr_n;
    end
  end

  // Start bit is checked at mid-bit; every later sample is one full bit
  // period on, so data and stop are also sampled mid-bit and IDLE is
  // re-entered half a bit before the next frame can begin.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    push    = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: if (cnt == HALF) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n        = '0;
        shift_n[idx] = rxs;
        idx_n        = idx + 1'b1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_n   = '0;
        state_n = IDLE;
        if (rxs) push   = 1'b1;
        else     ferr_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !empty;
  assign ovr_set  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (ovr_set)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

  sync_fifo #(
    .WIDTH(UART_DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (shift),
    .pop  (pop),
    .dout (rx_data),
    .full (full),
    .empty(empty),
    .count(rx_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at 8 clocks per bit,
// 8-entry FIFO. Inputs change on the falling edge, outputs are read there.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int ferr_cycles = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_cycles <= ferr_cycles + 1;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  // Drives one frame slot per falling edge (10 bits x CPB slots). With the
  // line dropping at slot 0, the stop sample and the push land on the rising
  // edge following slot 78, so pop_at/clr_at = 78 hit the push cycle.
  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int pop_at, input int clr_at, input int nslots);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int t = 0; t < nslots; t++) begin
      rxd         = fr[t/CPB];
      rx_ready    = (t == pop_at);
      overrun_clr = (t == clr_at);
      @(negedge clk);
    end
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    tests++; if (rx_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", rx_count); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", rx_data); end
    tests++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL reset_flags: ferr=%b ovr=%b want 0 0", frame_err, overrun); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_single();
    send_byte(8'h47, 1'b1, -1, -1, 80);
    idle(4);
    tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h47) begin fails++; $display("FAIL single_data: valid=%b data=%h want 1 47", rx_valid, rx_data); end
    tests++; if (rx_count !== 4'd1) begin fails++; $display("FAIL single_count: got %0d want 1", rx_count); end
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    tests++; if (rx_count !== 4'd0 || rx_valid !== 1'b0) begin fails++; $display("FAIL single_pop: count=%0d valid=%b want 0 0", rx_count, rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5];
    int f0;
    seq = '{8'h47, 8'h00, 8'h30, 8'h00, 8'h80};
    f0 = ferr_cycles;
    for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b1, -1, -1, 80);
    idle(4);
    tests++; if (rx_count !== 4'd5) begin fails++; $display("FAIL b2b_count: got %0d want 5", rx_count); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (rx_valid !== 1'b1 || rx_data !== seq[i]) begin fails++; $display("FAIL b2b_pop%0d: valid=%b data=%h want 1 %h", i, rx_valid, rx_data, seq[i]); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    end
    tests++; if (ferr_cycles != f0 || rx_count !== 4'd0) begin fails++; $display("FAIL b2b_end: ferr_cycles=%0d count=%0d want %0d 0", ferr_cycles, rx_count, f0); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cycles;
    send_byte(8'h55, 1'b0, -1, -1, 80);
    idle(12);
    tests++; if (ferr_cycles != f0 + 1) begin fails++; $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_cycles - f0); end
    tests++; if (rx_count !== 4'd0 || rx_valid !== 1'b0) begin fails++; $display("FAIL ferr_nopush: count=%0d valid=%b want 0 0", rx_count, rx_valid); end
    send_byte(8'hAA, 1'b1, -1, -1, 80);
    idle(4);
    tests++; if (rx_count !== 4'd1 || rx_data !== 8'hAA) begin fails++; $display("FAIL ferr_next: count=%0d data=%h want 1 aa", rx_count, rx_data); end
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_cycles;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(12);
    tests++; if (rx_count !== 4'd0 || ferr_cycles != f0) begin fails++; $display("FAIL glitch: count=%0d ferr_cycles=%0d want 0 %0d", rx_count, ferr_cycles, f0); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL glitch_state: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      send_byte(b, 1'b1, -1, -1, 80);
    end
    // Clear coincides with the dropped push: the set must win.
    send_byte(8'hEE, 1'b1, -1, 78, 80);
    idle(4);
    tests++; if (rx_count !== 4'd8) begin fails++; $display("FAIL ovr_count: got %0d want 8", rx_count); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      tests++; if (rx_valid !== 1'b1 || rx_data !== b) begin fails++; $display("FAIL ovr_pop%0d: valid=%b data=%h want 1 %h", i, rx_valid, rx_data, b); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    end
    tests++; if (rx_valid !== 1'b0 || overrun !== 1'b1) begin fails++; $display("FAIL ovr_drained: valid=%b ovr=%b want 0 1", rx_valid, overrun); end
    overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'h20 + 8'(i);
      send_byte(b, 1'b1, -1, -1, 80);
    end
    send_byte(8'h99, 1'b1, 78, -1, 80);
    idle(4);
    tests++; if (rx_count !== 4'd8 || overrun !== 1'b0) begin fails++; $display("FAIL fullpp: count=%0d ovr=%b want 8 0", rx_count, overrun); end
    for (int i = 1; i < 9; i++) begin
      b = (i == 8) ? 8'h99 : 8'h20 + 8'(i);
      tests++; if (rx_valid !== 1'b1 || rx_data !== b) begin fails++; $display("FAIL fullpp_pop%0d: valid=%b data=%h want 1 %h", i, rx_valid, rx_data, b); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    end
    tests++; if (rx_count !== 4'd0) begin fails++; $display("FAIL fullpp_end: count=%0d want 0", rx_count); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h5A, 1'b1, -1, -1, 80);
    idle(4);
    // Abort 0x3C partway through its data bits.
    send_byte(8'h3C, 1'b1, -1, -1, 40);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    tests++; if (rx_valid !== 1'b0 || rx_count !== 4'd0 || rx_data !== 8'h00) begin fails++; $display("FAIL midrst_vals: valid=%b count=%0d data=%h want 0 0 00", rx_valid, rx_count, rx_data); end
    tests++; if (frame_err !== 1'b0 || overrun !== 1'b0 || dut.state !== IDLE) begin fails++; $display("FAIL midrst_flags: ferr=%b ovr=%b state=%0d want 0 0 IDLE", frame_err, overrun, dut.state); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    send_byte(8'h81, 1'b1, -1, -1, 80);
    idle(4);
    tests++; if (rx_count !== 4'd1 || rx_data !== 8'h81) begin fails++; $display("FAIL midrst_next: count=%0d data=%h want 1 81", rx_count, rx_data); end
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_full_pop_push();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
